// File: rtl/param_seviyeli_hafiza.sv
// rtl/param_seviyeli_hafiza.sv - two-level address-tracking data memory with saturating fault counter
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   istek_gecerli / istek_hazir  request valid / ready (ready only in IDLE)
//   yazoku, adres, deger         request: 1=write 0=read, address, write data
//   sonuc, yanit_gecerli         read data, one-cycle response pulse
//   l1_hata, l2_hata             per-level miss flags, qualified by yanit_gecerli
//   hata_sayisi, sayac_sil       saturating fault count, synchronous clear
//   esik_asildi                  threshold flag (built only with HATA_ESIK_EN, else tied 0)
module param_seviyeli_hafiza #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8,
    parameter int BLOCK_W = 3,
    parameter int CNT_W   = 4
`ifdef HATA_ESIK_EN
    ,
    parameter int ESIK    = 3
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              istek_gecerli,
    output logic              istek_hazir,
    input  logic              yazoku,
    input  logic [ADDR_W-1:0] adres,
    input  logic [DATA_W-1:0] deger,
    output logic [DATA_W-1:0] sonuc,
    output logic              yanit_gecerli,
    output logic              l1_hata,
    output logic              l2_hata,
    output logic [CNT_W-1:0]  hata_sayisi,
    input  logic              sayac_sil,
    output logic              esik_asildi
);

    localparam int TAG_W = ADDR_W - 1 - BLOCK_W;
    localparam int BLK_W = ADDR_W - BLOCK_W;
    localparam int NBLK  = 2**BLK_W;
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [1:0] {IDLE, L1, L2, OKU} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                l1_valid [2];
    logic [TAG_W-1:0]    l1_tag [2];
    logic                l2_valid [NBLK];
    logic [BLOCK_W-1:0]  l2_ofs [NBLK];
    logic                f1, f2;
    logic [CNT_W-1:0]    cnt, cnt_next;

    logic                accept;
    logic                q_half;
    logic [BLK_W-1:0]    q_blk;
    logic [BLOCK_W-1:0]  q_ofs;
    logic [TAG_W-1:0]    q_tag;
    logic                miss1, miss2, miss;

    assign istek_hazir = (state == IDLE);
    assign accept      = istek_gecerli & istek_hazir;
    assign hata_sayisi = cnt;

    assign q_half = addr_q[ADDR_W-1];
    assign q_blk  = addr_q[ADDR_W-1:BLOCK_W];
    assign q_ofs  = addr_q[BLOCK_W-1:0];
    assign q_tag  = addr_q[ADDR_W-2:BLOCK_W];

    assign miss1 = !l1_valid[q_half] || (l1_tag[q_half] != q_tag);
    assign miss2 = !l2_valid[q_blk]  || (l2_ofs[q_blk]  != q_ofs);
    // At most one level is evaluated per cycle, so the counter never needs +2.
    assign miss  = ((state == L1) && miss1) || ((state == L2) && miss2);

    always_comb begin
        cnt_next = cnt;
        if (sayac_sil)
            cnt_next = '0;
        else if (miss && (cnt != {CNT_W{1'b1}}))
            cnt_next = cnt + 1'b1;
    end

    // Data array has no reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (accept && yazoku)
            mem[adres] <= deger;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr_q        <= '0;
            sonuc         <= '0;
            yanit_gecerli <= 1'b0;
            l1_hata       <= 1'b0;
            l2_hata       <= 1'b0;
            f1            <= 1'b0;
            f2            <= 1'b0;
            cnt           <= '0;
            for (int i = 0; i < 2; i++) begin
                l1_valid[i] <= 1'b0;
                l1_tag[i]   <= '0;
            end
            for (int i = 0; i < NBLK; i++) begin
                l2_valid[i] <= 1'b0;
                l2_ofs[i]   <= '0;
            end
        end else begin
            yanit_gecerli <= 1'b0;
            cnt           <= cnt_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (yazoku) begin
                            yanit_gecerli <= 1'b1;
                            l1_hata       <= 1'b0;
                            l2_hata       <= 1'b0;
                        end else begin
                            addr_q <= adres;
                            state  <= L1;
                        end
                    end
                end
                L1: begin
                    f1 <= miss1;
                    if (miss1) begin
                        l1_valid[q_half] <= 1'b1;
                        l1_tag[q_half]   <= q_tag;
                    end
                    state <= L2;
                end
                L2: begin
                    f2 <= miss2;
                    if (miss2) begin
                        l2_valid[q_blk] <= 1'b1;
                        l2_ofs[q_blk]   <= q_ofs;
                    end
                    state <= OKU;
                end
                OKU: begin
                    sonuc         <= mem[addr_q];
                    l1_hata       <= f1;
                    l2_hata       <= f2;
                    yanit_gecerli <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

`ifdef HATA_ESIK_EN
    localparam logic [CNT_W-1:0] ESIK_V = CNT_W'(ESIK);
    logic esik_q;

    // Sticky: set when the count reaches the threshold, cleared only by sayac_sil or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            esik_q <= 1'b0;
        else if (sayac_sil)
            esik_q <= 1'b0;
        else if (cnt_next >= ESIK_V)
            esik_q <= 1'b1;
    end

    assign esik_asildi = esik_q;
`else
    assign esik_asildi = 1'b0;
`endif

endmodule

// File: tb/tb_param_seviyeli_hafiza.sv
// tb/tb_param_seviyeli_hafiza.sv - directed self-checking bench for param_seviyeli_hafiza
module tb_param_seviyeli_hafiza;

`ifdef HATA_ESIK_EN
    localparam bit ESIK_ON = 1'b1;
`else
    localparam bit ESIK_ON = 1'b0;
`endif
    localparam int CNT_MAX = 15;
    localparam int ESIK_T  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       istek_gecerli = 1'b0;
    logic       istek_hazir;
    logic       yazoku = 1'b0;
    logic [5:0] adres = '0;
    logic [7:0] deger = '0;
    logic [7:0] sonuc;
    logic       yanit_gecerli;
    logic       l1_hata;
    logic       l2_hata;
    logic [3:0] hata_sayisi;
    logic       sayac_sil = 1'b0;
    logic       esik_asildi;

    always #5 clk = ~clk;

    param_seviyeli_hafiza dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .istek_gecerli (istek_gecerli),
        .istek_hazir   (istek_hazir),
        .yazoku        (yazoku),
        .adres         (adres),
        .deger         (deger),
        .sonuc         (sonuc),
        .yanit_gecerli (yanit_gecerli),
        .l1_hata       (l1_hata),
        .l2_hata       (l2_hata),
        .hata_sayisi   (hata_sayisi),
        .sayac_sil     (sayac_sil),
        .esik_asildi   (esik_asildi)
    );

    int         n_chk = 0;
    int         n_pass = 0;
    int         exp_cnt = 0;
    bit         exp_esik = 1'b0;
    logic [7:0] last_sonuc = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic int sat_add(input int c, input int d);
        return (c + d > CNT_MAX) ? CNT_MAX : c + d;
    endfunction

    function automatic logic esik_now();
        return ESIK_ON & exp_esik;
    endfunction

    task automatic upd_esik();
        if (exp_cnt >= ESIK_T)
            exp_esik = 1'b1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        chk("wr_hazir", istek_hazir, 1);
        istek_gecerli = 1'b1; yazoku = 1'b1; adres = a; deger = d;
        @(negedge clk);
        istek_gecerli = 1'b0; yazoku = 1'b0;
        chk("wr_yanit", yanit_gecerli, 1);
        chk("wr_l1", l1_hata, 0);
        chk("wr_l2", l2_hata, 0);
        chk("wr_sonuc_hold", sonuc, last_sonuc);
    endtask

    // Response expected at the 4th falling edge after the drive edge (3 rising edges after accept).
    task automatic rd(input logic [5:0] a, input logic [7:0] d, input bit m1, input bit m2, input bit sil);
        @(negedge clk);
        chk("rd_hazir", istek_hazir, 1);
        istek_gecerli = 1'b1; yazoku = 1'b0; adres = a;
        @(negedge clk);
        istek_gecerli = 1'b0;
        chk("rd_l1st_yanit", yanit_gecerli, 0);
        chk("rd_l1st_hazir", istek_hazir, 0);
        if (sil) sayac_sil = 1'b1;
        @(negedge clk);
        sayac_sil = 1'b0;
        if (sil) begin
            exp_cnt = 0; exp_esik = 1'b0;
        end else begin
            exp_cnt = sat_add(exp_cnt, int'(m1));
        end
        upd_esik();
        chk("rd_after_l1_cnt", hata_sayisi, exp_cnt);
        chk("rd_after_l1_esik", esik_asildi, esik_now());
        chk("rd_l2st_yanit", yanit_gecerli, 0);
        @(negedge clk);
        exp_cnt = sat_add(exp_cnt, int'(m2));
        upd_esik();
        chk("rd_after_l2_cnt", hata_sayisi, exp_cnt);
        chk("rd_okust_yanit", yanit_gecerli, 0);
        @(negedge clk);
        chk("rd_yanit", yanit_gecerli, 1);
        chk("rd_sonuc", sonuc, d);
        chk("rd_l1_hata", l1_hata, m1);
        chk("rd_l2_hata", l2_hata, m2);
        chk("rd_cnt", hata_sayisi, exp_cnt);
        chk("rd_esik", esik_asildi, esik_now());
        chk("rd_hazir_resp", istek_hazir, 1);
        last_sonuc = d;
    endtask

    logic [5:0] btb_a [3];
    logic [7:0] btb_d [3];

    initial begin
        btb_a[0] = 6'h00; btb_d[0] = 8'h11;
        btb_a[1] = 6'h08; btb_d[1] = 8'h22;
        btb_a[2] = 6'h10; btb_d[2] = 8'h33;

        repeat (2) @(negedge clk);
        chk("rst_hazir", istek_hazir, 1);
        chk("rst_yanit", yanit_gecerli, 0);
        chk("rst_sonuc", sonuc, 0);
        chk("rst_l1", l1_hata, 0);
        chk("rst_l2", l2_hata, 0);
        chk("rst_cnt", hata_sayisi, 0);
        chk("rst_esik", esik_asildi, 0);
        rst_n = 1'b1;

        wr(6'h2C, 8'hA5);
        rd(6'h2C, 8'hA5, 1, 1, 0);
        rd(6'h2C, 8'hA5, 0, 0, 0);
        wr(6'h2D, 8'h5A);
        wr(6'h05, 8'hC3);
        rd(6'h2D, 8'h5A, 0, 1, 0);
        rd(6'h05, 8'hC3, 1, 1, 0);

        // Back-to-back writes, one per cycle with valid held high.
        @(negedge clk);
        istek_gecerli = 1'b1; yazoku = 1'b1;
        for (int i = 0; i < 3; i++) begin
            adres = btb_a[i]; deger = btb_d[i];
            @(negedge clk);
            chk("btb_yanit", yanit_gecerli, 1);
            chk("btb_hazir", istek_hazir, 1);
        end
        istek_gecerli = 1'b0; yazoku = 1'b0;

        // Alternating 0x00/0x08: L1 thrashes; count must stick at 15.
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0)
                rd(6'h00, 8'h11, (i != 0), (i < 2), 0);
            else
                rd(6'h08, 8'h22, 1'b1, (i < 2), 0);
        end
        chk("sat_cnt", hata_sayisi, CNT_MAX);

        // Clear coincides with the L1 miss edge of 0x10.
        rd(6'h10, 8'h33, 1, 1, 1);

        // Reset while the walk of 0x2C sits in L2.
        @(negedge clk);
        istek_gecerli = 1'b1; yazoku = 1'b0; adres = 6'h2C;
        @(negedge clk);
        istek_gecerli = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        exp_cnt = 0; exp_esik = 1'b0;
        @(negedge clk);
        chk("midrst_yanit", yanit_gecerli, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_yanit", yanit_gecerli, 0);
        end
        chk("midrst_hazir", istek_hazir, 1);
        chk("midrst_cnt", hata_sayisi, 0);
        chk("midrst_esik", esik_asildi, 0);
        rd(6'h2C, 8'hA5, 1, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/param_seviyeli_hafiza.md
Name: param_seviyeli_hafiza

Overview:
Parametrised two-level address-tracking data memory with a valid/ready request handshake and a saturating fault counter. A write completes in one cycle. A read walks level 1 (per-half block tag) and level 2 (per-block offset tag), one level per clock, then returns the data. Each level that misses raises a per-response fault flag and bumps the counter. The block serves as the memory model behind the team's address-translation experiments.

Parameters:
ADDR_W, 6, address width; memory depth is 2**ADDR_W words
DATA_W, 8, data word width
BLOCK_W, 3, offset bits within a block; block size is 2**BLOCK_W words
CNT_W, 4, fault counter width; counter saturates at 2**CNT_W-1
ESIK, 3, fault threshold; used only when HATA_ESIK_EN is defined

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
istek_gecerli  in  1  request valid
istek_hazir  out  1  request ready; high only in IDLE
yazoku  in  1  1 = write, 0 = read; sampled on accept
adres  in  ADDR_W  request address; sampled on accept
deger  in  DATA_W  write data; sampled on accept
sonuc  out  DATA_W  read data; valid while yanit_gecerli is high
yanit_gecerli  out  1  one-cycle response pulse
l1_hata  out  1  level-1 miss on this read; qualified by yanit_gecerli
l2_hata  out  1  level-2 miss on this read; qualified by yanit_gecerli
hata_sayisi  out  CNT_W  saturating total fault count
sayac_sil  in  1  synchronous counter clear
esik_asildi  out  1  threshold flag; see Optional Feature

Behaviour:
- Address split: half = adres[ADDR_W-1]; blk = adres[ADDR_W-1:BLOCK_W]; ofs = adres[BLOCK_W-1:0]; l1tag = adres[ADDR_W-2:BLOCK_W].
- Level-1 table: 2 entries, one per half. Each entry is {valid, l1tag}.
- Level-2 table: 2**(ADDR_W-BLOCK_W) entries, one per blk. Each entry is {valid, ofs}.
- Reset clears all table valid bits and the counter. Data memory contents are not reset.
- Reset values: istek_hazir=1, yanit_gecerli=0, sonuc=0, l1_hata=0, l2_hata=0, hata_sayisi=0, esik_asildi=0; FSM in IDLE.
- Accept: istek_gecerli and istek_hazir both high at a rising edge.
- Write:
  - mem[adres]<=deger at the accept edge; FSM stays in IDLE.
  - yanit_gecerli pulses the following cycle with l1_hata=l2_hata=0; sonuc holds its previous value.
  - Writes never touch the tables. Back-to-back writes are supported, one per cycle.
- Read FSM: IDLE -> L1 -> L2 -> OKU -> IDLE. Address is latched at accept.
  - L1 edge: miss if the entry is invalid or its tag differs from l1tag. On a miss, write the entry {1, l1tag}, set the internal l1 flag and increment the counter.
  - L2 edge: same rule on the level-2 entry for blk against ofs; increment the counter on a miss.
  - OKU edge: sonuc<=mem[addr]; l1_hata and l2_hata driven from the internal flags; yanit_gecerli=1 for one cycle.
  - FSM returns to IDLE on the OKU edge, so a new request may be accepted in the cycle yanit_gecerli is high.
  - Read latency: the response appears 3 edges after accept.
- Counter: adds 1 per miss and saturates at 2**CNT_W-1 (no wrap). A read can miss at both levels, adding 2 over two cycles. sayac_sil has priority over a same-cycle increment; the result is 0.
- Reset mid-walk: FSM returns to IDLE and no response is issued. Table entries already written by the interrupted walk are cleared along with all others.

Optional Feature:
Macro HATA_ESIK_EN.
- Defined: esik_asildi is registered. It sets on the edge where hata_sayisi becomes >=ESIK and stays high until sayac_sil or reset.
- Undefined: esik_asildi is tied 0 and no threshold logic is built.

Test Plan:
- Reset; write 0xA5 @0x2C; read 0x2C -> response 3 edges after accept: sonuc=0xA5, l1_hata=1, l2_hata=1, hata_sayisi=2.
- Then read 0x2C -> no faults, count 2. Read 0x2D -> l2_hata only, count 3. Read 0x05 -> both faults, count 5.
- Alternate reads 0x00/0x08 ten times each -> hata_sayisi stops at 15, never wraps to 0.
- Assert sayac_sil in the same cycle as the L1 miss edge of read 0x10 -> hata_sayisi=0 after that edge, then 1 after the L2 miss edge.
- Pulse rst_n low while FSM is in L2 -> no yanit_gecerli; istek_hazir=1 and count 0 after release; re-read of the same address reports both faults.
- With HATA_ESIK_EN and ESIK=3: fresh read 0x00 (count 2) keeps esik_asildi=0; then read 0x01 -> esik_asildi=1 and stays high; sayac_sil clears it. Without the macro, esik_asildi stays 0 throughout.
